reg_file_scoreboard: RTL and testbench

- Parametrised 2-read/1-write register file for the CPU datapath, with a per-register busy scoreboard for interlock.
- Decode reserves a destination register at issue; writeback clears the reservation when it writes the result.
- Read ports return data plus a busy flag. Write-to-read bypass and an optional registered read stage are built in.
- Generalises the fixed 32x32 file to any width/depth; optional hardwired zero register.

---
 rtl/reg_file_scoreboard.sv | 99 +++++++++
 tb/tb_reg_file_scoreboard.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/reg_file_scoreboard.sv
// Parametrised 2-read/1-write register file with a per-register busy scoreboard.
// Reads bypass the same-cycle write; the read stage can optionally be registered.
module reg_file_scoreboard #(
    parameter int DATA_WIDTH      = 32,
    parameter int ADDR_WIDTH      = 5,
    parameter int ZERO_REG        = 1,
    parameter int REGISTERED_READ = 0
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic [ADDR_WIDTH-1:0] RegAID,
    input  logic [ADDR_WIDTH-1:0] RegBID,
    output logic [DATA_WIDTH-1:0] QA,
    output logic [DATA_WIDTH-1:0] QB,
    output logic                  BusyA,
    output logic                  BusyB,
    input  logic [DATA_WIDTH-1:0] DataIn,
    input  logic [ADDR_WIDTH-1:0] RegIDToWrite,
    input  logic                  EnableWrite,
    input  logic [ADDR_WIDTH-1:0] ReserveID,
    input  logic                  EnableReserve,
    output logic                  ReserveReady
);
    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0]      busy;

    logic                  writeHit;
    logic [DATA_WIDTH-1:0] readA;
    logic [DATA_WIDTH-1:0] readB;
    logic                  readBusyA;
    logic                  readBusyB;

    function automatic logic isZero(input logic [ADDR_WIDTH-1:0] idx);
        return (ZERO_REG != 0) && (idx == '0);
    endfunction

    assign writeHit = EnableWrite & ~isZero(RegIDToWrite);

    assign ReserveReady = EnableReserve & ~isZero(ReserveID) &
                          (~busy[ReserveID] | (EnableWrite & (RegIDToWrite == ReserveID)));

    // Reserve is applied after the write so a same-index reserve leaves the bit set.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (writeHit) begin
                regs[RegIDToWrite] <= DataIn;
                busy[RegIDToWrite] <= 1'b0;
            end
            if (ReserveReady) begin
                busy[ReserveID] <= 1'b1;
            end
        end
    end

    always_comb begin
        readA     = '0;
        readB     = '0;
        readBusyA = 1'b0;
        readBusyB = 1'b0;
        if (!isZero(RegAID)) begin
            readA     = (writeHit && RegIDToWrite == RegAID) ? DataIn : regs[RegAID];
            readBusyA = busy[RegAID] & ~(EnableWrite & (RegIDToWrite == RegAID));
        end
        if (!isZero(RegBID)) begin
            readB     = (writeHit && RegIDToWrite == RegBID) ? DataIn : regs[RegBID];
            readBusyB = busy[RegBID] & ~(EnableWrite & (RegIDToWrite == RegBID));
        end
    end

    if (REGISTERED_READ != 0) begin : gRegRead
        always_ff @(posedge Clock) begin
            if (Reset) begin
                QA    <= '0;
                QB    <= '0;
                BusyA <= 1'b0;
                BusyB <= 1'b0;
            end else begin
                QA    <= readA;
                QB    <= readB;
                BusyA <= readBusyA;
                BusyB <= readBusyB;
            end
        end
    end else begin : gCombRead
        always_comb begin
            QA    = readA;
            QB    = readB;
            BusyA = readBusyA;
            BusyB = readBusyB;
        end
    end
endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed bench: a combinational-read and a registered-read instance share all inputs.
module tb_reg_file_scoreboard;
    logic        Clock = 1'b0;
    logic        Reset;
    logic [4:0]  RegAID, RegBID, RegIDToWrite, ReserveID;
    logic [31:0] DataIn;
    logic        EnableWrite, EnableReserve;

    logic [31:0] QA, QB, qaR, qbR;
    logic        BusyA, BusyB, ReserveReady, busyAR, busyBR, reserveReadyR;

    int errors = 0;
    int checks = 0;

    always #5 Clock = ~Clock;

    reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .REGISTERED_READ(0)) dutComb (
        .Clock(Clock), .Reset(Reset), .RegAID(RegAID), .RegBID(RegBID),
        .QA(QA), .QB(QB), .BusyA(BusyA), .BusyB(BusyB),
        .DataIn(DataIn), .RegIDToWrite(RegIDToWrite), .EnableWrite(EnableWrite),
        .ReserveID(ReserveID), .EnableReserve(EnableReserve), .ReserveReady(ReserveReady)
    );

    reg_file_scoreboard #(.DATA_WIDTH(32), .ADDR_WIDTH(5), .ZERO_REG(1), .REGISTERED_READ(1)) dutReg (
        .Clock(Clock), .Reset(Reset), .RegAID(RegAID), .RegBID(RegBID),
        .QA(qaR), .QB(qbR), .BusyA(busyAR), .BusyB(busyBR),
        .DataIn(DataIn), .RegIDToWrite(RegIDToWrite), .EnableWrite(EnableWrite),
        .ReserveID(ReserveID), .EnableReserve(EnableReserve), .ReserveReady(reserveReadyR)
    );

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    initial begin
        Reset = 1'b1; RegAID = '0; RegBID = '0; RegIDToWrite = '0; ReserveID = '0;
        DataIn = '0; EnableWrite = 1'b0; EnableReserve = 1'b0;
        tick();
        tick();
        Reset = 1'b0;
        #1;

        // 1: all registers zero after reset, reset clears a written value
        for (int i = 0; i < 32; i++) begin
            RegAID = 5'(i);
            RegBID = 5'(31 - i);
            #1;
            checkEq("rstQA", QA, 32'h0);
            checkEq("rstQB", QB, 32'h0);
            checkEq("rstBusyA", 32'(BusyA), 32'h0);
            checkEq("rstBusyB", 32'(BusyB), 32'h0);
        end
        checkEq("rstQAreg", qaR, 32'h0);
        checkEq("rstBusyAreg", 32'(busyAR), 32'h0);
        EnableWrite = 1'b1; RegIDToWrite = 5'd5; DataIn = 32'hDEADBEEF;
        tick();
        EnableWrite = 1'b0; RegAID = 5'd5;
        #1;
        checkEq("r5Written", QA, 32'hDEADBEEF);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        #1;
        checkEq("r5AfterReset", QA, 32'h0);

        // 2: reserve, refused WAW reserve, writeback clears busy with bypass
        EnableReserve = 1'b1; ReserveID = 5'd7; RegAID = 5'd7;
        #1;
        checkEq("r7ReserveReady", 32'(ReserveReady), 32'h1);
        checkEq("r7BusySameCycle", 32'(BusyA), 32'h0);
        tick();
        checkEq("r7BusyNext", 32'(BusyA), 32'h1);
        checkEq("r7WawRefused", 32'(ReserveReady), 32'h0);
        EnableReserve = 1'b0;
        EnableWrite = 1'b1; RegIDToWrite = 5'd7; DataIn = 32'h12345678;
        #1;
        checkEq("r7BypassQA", QA, 32'h12345678);
        checkEq("r7BypassBusy", 32'(BusyA), 32'h0);
        tick();
        EnableWrite = 1'b0;
        #1;
        checkEq("r7QAAfter", QA, 32'h12345678);
        checkEq("r7BusyAfter", 32'(BusyA), 32'h0);

        // 3: register zero is hardwired
        EnableWrite = 1'b1; RegIDToWrite = 5'd0; DataIn = 32'hFFFFFFFF;
        EnableReserve = 1'b1; ReserveID = 5'd0; RegAID = 5'd0; RegBID = 5'd0;
        #1;
        checkEq("r0ReserveReady", 32'(ReserveReady), 32'h0);
        checkEq("r0QABypass", QA, 32'h0);
        checkEq("r0BusyA", 32'(BusyA), 32'h0);
        tick();
        EnableWrite = 1'b0; EnableReserve = 1'b0;
        #1;
        checkEq("r0QAAfter", QA, 32'h0);
        checkEq("r0QBAfter", QB, 32'h0);
        checkEq("r0BusyAfter", 32'(BusyA), 32'h0);

        // 4: same-edge write and reserve on a busy register, reserve wins
        EnableReserve = 1'b1; ReserveID = 5'd9;
        tick();
        EnableWrite = 1'b1; RegIDToWrite = 5'd9; DataIn = 32'hA5A5A5A5;
        #1;
        checkEq("r9ReserveOverWrite", 32'(ReserveReady), 32'h1);
        tick();
        EnableWrite = 1'b0; EnableReserve = 1'b0; RegAID = 5'd9;
        #1;
        checkEq("r9Data", QA, 32'hA5A5A5A5);
        checkEq("r9Busy", 32'(BusyA), 32'h1);

        // 5: registered read has exactly one cycle of latency
        tick();
        RegAID = 5'd3; EnableWrite = 1'b1; RegIDToWrite = 5'd3; DataIn = 32'h00000042;
        #1;
        checkEq("regPriorQA", qaR, 32'hA5A5A5A5);
        checkEq("regPriorBusy", 32'(busyAR), 32'h1);
        checkEq("combBypassR3", QA, 32'h00000042);
        tick();
        EnableWrite = 1'b0; RegAID = 5'd4;
        #1;
        checkEq("regQAR3", qaR, 32'h00000042);
        checkEq("regBusyR3", 32'(busyAR), 32'h0);
        tick();
        checkEq("regQAR4", qaR, 32'h0);

        // 6: reset discards a pending reservation and drops the same-cycle write
        EnableReserve = 1'b1; ReserveID = 5'd12;
        tick();
        EnableReserve = 1'b0; RegAID = 5'd12;
        #1;
        checkEq("r12BusyBefore", 32'(BusyA), 32'h1);
        Reset = 1'b1; EnableWrite = 1'b1; RegIDToWrite = 5'd20; DataIn = 32'h00000055;
        tick();
        Reset = 1'b0; EnableWrite = 1'b0; RegBID = 5'd20;
        #1;
        checkEq("r12BusyAfterReset", 32'(BusyA), 32'h0);
        checkEq("r20WriteDropped", QB, 32'h0);
        checkEq("regBusyAfterReset", 32'(busyAR), 32'h0);
        checkEq("regQAAfterReset", qaR, 32'h0);
        EnableReserve = 1'b1; ReserveID = 5'd12;
        #1;
        checkEq("r12ReserveAfterReset", 32'(ReserveReady), 32'h1);
        EnableReserve = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule
